// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the HI/LO multiply unit
//
// Purpose : FSM state type, data word width and multiply iteration count
//           used by the multiplier, its datapath and its bus interface.
// Ports   : none (package).
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int MULT_ITERS = WORD_W;

  typedef enum logic {
    IDLE,
    RUN
  } mult_state_t;

endpackage

// File: rtl/mult_hilo_unit_if.sv
// rtl/mult_hilo_unit_if.sv - control/datapath bus of the HI/LO multiply unit
//
// Purpose : bundles the start request, operands, special-function read
//           select and the unit's result/status signals.
// Modports: master - control unit / datapath side (drives request, operands)
//           slave  - the multiply unit (drives hi, lo, sf_out, status)
interface mult_hilo_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
);

  logic             mult_enable;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sfmux_high;
  logic             sf2reg;
  logic [WIDTH-1:0] sf_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output mult_enable, a, b, sfmux_high, sf2reg,
    input  sf_out, hi, lo, busy, done, stall
  );

  modport slave (
    input  mult_enable, a, b, sfmux_high, sf2reg,
    output sf_out, hi, lo, busy, done, stall
  );

endinterface

// File: rtl/mult_shift_add_dp.sv
// rtl/mult_shift_add_dp.sv - shift-and-add multiply datapath
//
// Purpose : multiplicand, multiplier and accumulator registers with the
//           conditional adder for one radix-2 multiply step per cycle.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           load          - capture a (zero-extended), b; clear accumulator
//           step          - perform one add/shift iteration
//           a, b          - operands
//           acc_next      - accumulator value after the current step
module mult_shift_add_dp
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;

  // Exposed so the top can capture the final step's sum on the same edge.
  // The sum fits in 2*WIDTH bits for unsigned operands, so wrap is harmless.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - multi-cycle unsigned multiplier with HI/LO registers
//
// Purpose : accepts MULTU starts, runs WIDTH shift-add iterations, updates
//           HI/LO on completion, serves MFHI/MFLO reads and stalls the
//           datapath while a multiply is in flight.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset (discards in-flight result)
//           bus  - slave side of mult_hilo_unit_if (request, operands,
//                  sf select in; hi, lo, sf_out, busy, done, stall out)
module mult_hilo_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_ITERS
) (
  input  logic            clk,
  input  logic            rst,
  mult_hilo_unit_if.slave bus
);

  localparam int                CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  mult_state_t        state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               load;
  logic               step;
  logic [2*WIDTH-1:0] acc_next;

  // Requests arriving while busy are neither accepted nor sampled; the
  // stall holds them until the first IDLE cycle.
  assign load = (state == IDLE) && bus.mult_enable;
  assign step = (state == RUN);

  mult_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .a        (bus.a),
    .b        (bus.b),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mult_enable) begin
            cnt    <= '0;
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            {hi_q, lo_q} <= acc_next;
            cnt          <= '0;
            state        <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  // While busy, sf_out still shows the old HI/LO; the stall keeps the
  // datapath from committing it.
  assign bus.sf_out = bus.sfmux_high ? hi_q : lo_q;
  assign bus.stall  = busy_q & (bus.mult_enable | bus.sf2reg);

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - self-checking bench for mult_hilo_unit
module tb_mult_hilo_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[5];

  mult_hilo_unit_if #(.WIDTH(32)) bus ();

  mult_hilo_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected product.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 want no done (hi=%0h lo=%0h)", bus.hi, bus.lo);
      end else begin
        automatic logic [63:0] e = exp_q.pop_front();
        check("hilo", {bus.hi, bus.lo}, e);
      end
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge after done.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
    int nb;
    bus.a = a;
    bus.b = b;
    bus.mult_enable = 1'b1;
    exp_q.push_back(p);
    #1 check("idle_start_stall", bus.stall, 0);
    @(negedge clk);
    bus.mult_enable = 1'b0;
    nb = 0;
    while (bus.busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    check("busy_cycles", nb, 32);
    check("done_pulse", bus.done, 1);
    @(negedge clk);
    check("done_clear", bus.done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int ns;
    bit any_done;

    vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,         32'h0001_2345, 64'd0};
    vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0)};
    vecs[4] = '{32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000};

    bus.mult_enable = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.sfmux_high  = 1'b0;
    bus.sf2reg      = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_sf_out", bus.sf_out, 0);

    // Table-driven products
    for (int i = 0; i < 5; i++) begin
      do_mult(vecs[i].a, vecs[i].b, vecs[i].p);
      bus.sfmux_high = 1'b0;
      #1 check("sf_out_lo", bus.sf_out, vecs[i].p[31:0]);
      bus.sfmux_high = 1'b1;
      #1 check("sf_out_hi", bus.sf_out, vecs[i].p[63:32]);
      @(negedge clk);
    end

    // MFHI while busy: stall and old HI (1), then new HI (2) without stall
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'd3;
    bus.mult_enable = 1'b1;
    bus.sfmux_high = 1'b1;
    exp_q.push_back(64'h0000_0002_FFFF_FFFD);
    @(negedge clk);
    bus.mult_enable = 1'b0;
    bus.sf2reg = 1'b1;
    #1;
    check("busy_sf_stall", bus.stall, 1);
    check("busy_sf_old_hi", bus.sf_out, 1);
    nb = 0;
    while (bus.busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    check("sf_busy_cycles", nb, 32);
    check("post_sf_stall", bus.stall, 0);
    check("post_sf_new_hi", bus.sf_out, 2);
    bus.sf2reg = 1'b0;
    @(negedge clk);

    // Reset in the middle of RUN discards the product
    bus.a = 32'h1234;
    bus.b = 32'h5678;
    bus.mult_enable = 1'b1;
    @(negedge clk);
    bus.mult_enable = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_hi", bus.hi, 0);
    check("midrst_lo", bus.lo, 0);
    any_done = 1'b0;
    repeat (40) begin
      if (bus.done) any_done = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_done", any_done, 0);
    do_mult(32'd7, 32'd6, 64'd42);

    // Request held through a multiply: stalled 32 cycles, then accepted
    bus.a = 32'd1000;
    bus.b = 32'd2000;
    bus.mult_enable = 1'b1;
    exp_q.push_back(64'd2_000_000);
    @(negedge clk);
    bus.a = 32'd10;
    bus.b = 32'd10;
    exp_q.push_back(64'd100);
    ns = 0;
    nb = 0;
    while (bus.busy && nb < 100) begin
      nb++;
      if (bus.stall) ns++;
      @(negedge clk);
    end
    check("held_stall_cycles", ns, 32);
    check("held_done", bus.done, 1);
    check("held_idle_stall", bus.stall, 0);
    @(negedge clk);
    check("held_accepted", bus.busy, 1);
    bus.mult_enable = 1'b0;
    nb = 0;
    while (bus.busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    check("held_second_busy", nb, 32);
    check("held_second_done", bus.done, 1);
    check("held_second_lo", bus.lo, 100);
    @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
